// File: rtl/jtag_pkg.sv
// ---------------------------------------------------------------------------
// jtag_pkg
// Shared definitions for the JTAG LED TAP:
//   - tap_state_t : the 16 IEEE 1149.1 TAP controller states, using the
//                   conventional 4-bit encodings that appear on TAP_STATE.
//   - IDCODE, LED_WR, SW_RD, BYPASS : 4-bit instruction codes. They are
//                   zero-extended when the instruction register is wider.
// ---------------------------------------------------------------------------
package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR_SCAN   = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR_SCAN   = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam logic [3:0] IDCODE = 4'h1;
    localparam logic [3:0] LED_WR = 4'h2;
    localparam logic [3:0] SW_RD  = 4'h3;
    localparam logic [3:0] BYPASS = 4'hF;

    // Widest data register the block can select (IDCODE, LED and switches are
    // all limited to 32 bits).
    localparam int DR_MAX_W = 32;

endpackage

// File: rtl/jtag_tap_fsm.sv
// ---------------------------------------------------------------------------
// jtag_tap_fsm
// IEEE 1149.1 TAP controller: state register and TMS-driven next-state logic.
// Ports:
//   TCK   in  : test clock, all transitions on the rising edge
//   TRST  in  : synchronous active-high reset to TEST_LOGIC_RESET
//   TMS   in  : mode select, sampled on the TCK rising edge
//   state out : current TAP state
// ---------------------------------------------------------------------------
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_t state
);

    tap_state_t state_q, state_d;

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TEST_LOGIC_RESET: state_d = TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   state_d = TMS ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       state_d = TMS ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = TMS ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = TMS ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = TMS ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = TMS ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   state_d = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = TMS ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = TMS ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = TMS ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = TMS ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = TMS ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/jtag_led_tap.sv
// ---------------------------------------------------------------------------
// jtag_led_tap
// JTAG test-access port giving a host access to an IDCODE, a writable LED
// register and the board switches over TMS/TDI/TDO.
// Ports:
//   TCK       in            : sole clock
//   TRST      in            : synchronous active-high reset
//   TMS       in            : TAP mode select
//   TDI       in            : serial data in
//   TDO       out           : registered serial data out
//   SWITCH    in  SW_COUNT  : synchronised board switches
//   LED       out LED_COUNT : LED drive
//   TAP_STATE out 4         : current TAP state encoding
// Optional feature macro: JTAG_SWITCH_OVERRIDE_EN
//   When defined, SWITCH[0]=0 forces the LED pins to LED_RESET while the LED
//   register itself keeps updating and remains readable.
// ---------------------------------------------------------------------------
module jtag_led_tap
    import jtag_pkg::*;
#(
    parameter int                   LED_COUNT  = 8,
    parameter int                   SW_COUNT   = 1,
    parameter int                   IR_WIDTH   = 4,
    parameter logic [31:0]          IDCODE_VAL = 32'h1000_0001,
    parameter logic [LED_COUNT-1:0] LED_RESET  = LED_COUNT'(8'b10011001)
) (
    input  logic                 TCK,
    input  logic                 TRST,
    input  logic                 TMS,
    input  logic                 TDI,
    output logic                 TDO,
    input  logic [SW_COUNT-1:0]  SWITCH,
    output logic [LED_COUNT-1:0] LED,
    output logic [3:0]           TAP_STATE
);

    // Counter must be able to exceed both the longest DR and the IR length.
    localparam int CNT_W = $clog2(((IR_WIDTH > DR_MAX_W) ? IR_WIDTH : DR_MAX_W) + 2);

    tap_state_t state;

    logic [IR_WIDTH-1:0]  ir_q, ir_d;
    logic [IR_WIDTH-1:0]  ir_sr_q, ir_sr_d;
    logic [DR_MAX_W-1:0]  dr_sr_q, dr_sr_d;
    logic [LED_COUNT-1:0] led_q, led_d;
    logic                 tdo_q, tdo_d;
    logic [CNT_W-1:0]     shift_cnt_q, shift_cnt_d;

    logic [4:0]           dr_msb;
    logic [DR_MAX_W-1:0]  dr_capture;
    logic                 sel_led;
    logic                 dr_done;
    logic                 ir_done;

    jtag_tap_fsm u_fsm (
        .TCK   (TCK),
        .TRST  (TRST),
        .TMS   (TMS),
        .state (state)
    );

    // Instruction decode: selected DR length (as its MSB index) and capture
    // value. Unknown codes fall through to the 1-bit bypass register.
    always_comb begin
        dr_msb     = 5'd0;
        dr_capture = '0;
        sel_led    = 1'b0;
        if (ir_q == IR_WIDTH'(IDCODE)) begin
            dr_msb     = 5'(DR_MAX_W - 1);
            dr_capture = IDCODE_VAL;
        end else if (ir_q == IR_WIDTH'(LED_WR)) begin
            dr_msb     = 5'(LED_COUNT - 1);
            dr_capture = DR_MAX_W'(led_q);
            sel_led    = 1'b1;
        end else if (ir_q == IR_WIDTH'(SW_RD)) begin
            dr_msb     = 5'(SW_COUNT - 1);
            dr_capture = DR_MAX_W'(SWITCH);
        end else if (ir_q == IR_WIDTH'(BYPASS)) begin
            dr_msb     = 5'd0;
            dr_capture = '0;
        end
    end

    // An UPDATE is honoured only once a full register length has been shifted
    // since CAPTURE, so escaping a scan early (e.g. the five-TMS=1 path to
    // TEST_LOGIC_RESET, which walks through UPDATE_DR) never commits a
    // partially shifted value.
    assign dr_done = (shift_cnt_q > CNT_W'(dr_msb));
    assign ir_done = (shift_cnt_q >= CNT_W'(IR_WIDTH));

    always_comb begin
        ir_d        = ir_q;
        ir_sr_d     = ir_sr_q;
        dr_sr_d     = dr_sr_q;
        led_d       = led_q;
        tdo_d       = 1'b0;
        shift_cnt_d = shift_cnt_q;
        case (state)
            TEST_LOGIC_RESET: begin
                ir_d = IR_WIDTH'(IDCODE);
            end
            CAPTURE_IR: begin
                ir_sr_d     = IR_WIDTH'(1);
                shift_cnt_d = '0;
            end
            SHIFT_IR: begin
                ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
                tdo_d   = ir_sr_q[0];
                if (shift_cnt_q != '1) shift_cnt_d = shift_cnt_q + CNT_W'(1);
            end
            UPDATE_IR: begin
                if (ir_done) ir_d = ir_sr_q;
            end
            CAPTURE_DR: begin
                dr_sr_d     = dr_capture;
                shift_cnt_d = '0;
            end
            SHIFT_DR: begin
                // TDI enters at the MSB of the selected register's length;
                // bits above it stay zero from the capture.
                dr_sr_d         = dr_sr_q >> 1;
                dr_sr_d[dr_msb] = TDI;
                tdo_d           = dr_sr_q[0];
                if (shift_cnt_q != '1) shift_cnt_d = shift_cnt_q + CNT_W'(1);
            end
            UPDATE_DR: begin
                if (sel_led && dr_done) led_d = dr_sr_q[LED_COUNT-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_q        <= IR_WIDTH'(IDCODE);
            ir_sr_q     <= '0;
            dr_sr_q     <= '0;
            led_q       <= LED_RESET;
            tdo_q       <= 1'b0;
            shift_cnt_q <= '0;
        end else begin
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            dr_sr_q     <= dr_sr_d;
            led_q       <= led_d;
            tdo_q       <= tdo_d;
            shift_cnt_q <= shift_cnt_d;
        end
    end

    assign TDO       = tdo_q;
    assign TAP_STATE = state;

`ifdef JTAG_SWITCH_OVERRIDE_EN
    assign LED = SWITCH[0] ? led_q : LED_RESET;
`else
    assign LED = led_q;
`endif

endmodule
